// File: rtl/vdac_seq_pkg.sv
// rtl/vdac_seq_pkg.sv - shared types and constants for the vdac playback sequencer
package vdac_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sign-magnitude zero code: only the sign bit set.
  function automatic int unsigned mid_of(input int unsigned bw);
    return 32'd1 << (bw - 1);
  endfunction

  // Table address width; a single-entry table still needs one address bit.
  function automatic int unsigned aw_of(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/vdac_seq_tbl.sv
// rtl/vdac_seq_tbl.sv - waveform table register file, sync write, async read
module vdac_seq_tbl
  import vdac_seq_pkg::*;
#(
  parameter int BITWIDTH = 6,
  parameter int DEPTH    = 8,
  localparam int AW      = aw_of(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [BITWIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [BITWIDTH-1:0] o_rd_data
);

  localparam logic [BITWIDTH-1:0] MID = BITWIDTH'(mid_of(BITWIDTH));

  logic [BITWIDTH-1:0] mem [DEPTH];

  // Entries reset to the zero code so an unwritten table plays silence.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= MID;
      end
    end else if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // The read is combinational, so a same-edge write is only seen on a later fetch.
  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/vdac_seq.sv
// rtl/vdac_seq.sv - sample-playback sequencer driving the sign-magnitude vdac
module vdac_seq
  import vdac_seq_pkg::*;
#(
  parameter int BITWIDTH = 6,
  parameter int DEPTH    = 8,
  parameter int DIVW     = 8,
  localparam int AW      = aw_of(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [BITWIDTH-1:0] i_wr_data,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_loop,
  input  logic [AW-1:0]       i_len,
  input  logic [DIVW-1:0]     i_div,
  output logic [BITWIDTH-1:0] o_data,
  output logic                o_enable,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [BITWIDTH-1:0] MID = BITWIDTH'(mid_of(BITWIDTH));

  state_t              state;
  logic [AW-1:0]       idx;
  logic [DIVW-1:0]     cnt;
  logic [AW-1:0]       len_l;
  logic [DIVW-1:0]     div_l;
  logic                loop_l;
  logic [AW-1:0]       rd_addr;
  logic [BITWIDTH-1:0] rd_data;

  vdac_seq_tbl #(
    .BITWIDTH(BITWIDTH),
    .DEPTH   (DEPTH)
  ) u_tbl (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr_en  (i_wr_en),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .i_rd_addr(rd_addr),
    .o_rd_data(rd_data)
  );

  // Fetch address is the sample that would be shown after the next advance.
  always_comb begin
    rd_addr = '0;
    if (state == ST_PLAY && idx < len_l) begin
      rd_addr = idx + AW'(1);
    end
  end

  // Playback FSM with rate divider; every output is registered here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      cnt      <= '0;
      len_l    <= '0;
      div_l    <= '0;
      loop_l   <= 1'b0;
      o_data   <= MID;
      o_enable <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            len_l    <= i_len;
            div_l    <= i_div;
            loop_l   <= i_loop;
            idx      <= '0;
            cnt      <= '0;
            state    <= ST_PLAY;
            o_data   <= rd_data;
            o_enable <= 1'b1;
            o_busy   <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (i_stop) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cnt      <= '0;
            o_data   <= MID;
            o_enable <= 1'b0;
            o_busy   <= 1'b0;
          end else if (cnt == div_l) begin
            cnt <= '0;
            if (idx < len_l) begin
              idx    <= idx + AW'(1);
              o_data <= rd_data;
            end else if (loop_l) begin
              idx    <= '0;
              o_data <= rd_data;
            end else begin
              state    <= ST_DONE;
              idx      <= '0;
              o_data   <= MID;
              o_enable <= 1'b0;
              o_busy   <= 1'b0;
              o_done   <= 1'b1;
            end
          end else begin
            cnt <= cnt + DIVW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
